// File: rtl/answer_arbiter.sv
// answer_arbiter: round controller and first-press arbiter for the quiz responder.
// Arms a round on the host's start pulse and runs the maxtime countdown. It grants
// the first valid contestant press, then applies the host's right/wrong judgement
// to that contestant's saturating score register.
// Optional feature macro: FOUL_EN. When it is defined, a press in IDLE while the
// settings are valid pulses foul and deducts scorejian from that contestant.
// Assumes SCORE_W >= 3 so the 4-bit point values fit the SCORE_W+1 bit sums.
module answer_arbiter #(
   parameter int N_USER      = 8,
   parameter int SCORE_W     = 8,
   parameter int CLK_PER_SEC = 100000000
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        endset_i,
   input  logic [7:0]                  maxtime_i,
   input  logic [3:0]                  maxuser_i,
   input  logic [3:0]                  scorejia_i,
   input  logic [3:0]                  scorejian_i,
   input  logic                        start_i,
   input  logic [N_USER-1:0]           key_i,
   input  logic                        right_i,
   input  logic                        wrong_i,
   output logic                        busy_o,
   output logic [3:0]                  winner_o,
   output logic                        winner_vld_o,
   output logic [7:0]                  time_left_o,
   output logic                        timeout_o,
   output logic                        foul_o,
   output logic [N_USER*SCORE_W-1:0]   score_o
);

   localparam int PRE_W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);

   typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

   state_t                           state_q;
   logic [PRE_W-1:0]                 presc_q;
   logic [7:0]                       time_left_q;
   logic [3:0]                       winner_q;
   logic                             timeout_q;
   logic [N_USER-1:0]                key_q;
   logic [N_USER-1:0][SCORE_W-1:0]   score_q;

   logic                             grant_vld_d;
   logic [3:0]                       grant_idx_d;
   logic [SCORE_W-1:0]               win_score_d;

   // Saturating add. Sum is formed one bit wider, then clamped to all-ones.
   function automatic logic [SCORE_W-1:0] add_sat(input logic [SCORE_W-1:0] a,
                                                  input logic [3:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + (SCORE_W+1)'(b);
      return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
   endfunction

   // Saturating subtract. A borrow out of the wide difference clamps to zero.
   function automatic logic [SCORE_W-1:0] sub_sat(input logic [SCORE_W-1:0] a,
                                                  input logic [3:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} - (SCORE_W+1)'(b);
      return s[SCORE_W] ? {SCORE_W{1'b0}} : s[SCORE_W-1:0];
   endfunction

   // Rising-edge presses restricted to active users. The lowest index wins a tie.
   always_comb begin
      grant_vld_d = 1'b0;
      grant_idx_d = '0;
      for (int i = N_USER - 1; i >= 0; i--) begin
         if (key_i[i] && !key_q[i] && (5'(i) < {1'b0, maxuser_i})) begin
            grant_vld_d = 1'b1;
            grant_idx_d = 4'(i);
         end
      end
   end

   // Score of the currently granted contestant, used for the judgement update.
   always_comb begin
      win_score_d = '0;
      for (int i = 0; i < N_USER; i++)
         if (winner_q == 4'(i)) win_score_d = score_q[i];
   end

`ifdef FOUL_EN
   logic [SCORE_W-1:0] foul_score_d;
   logic               foul_q;

   // Score of the early presser, used for the foul deduction.
   always_comb begin
      foul_score_d = '0;
      for (int i = 0; i < N_USER; i++)
         if (grant_idx_d == 4'(i)) foul_score_d = score_q[i];
   end
`endif

   // Round FSM: arming, countdown, grant, judgement and the score registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         presc_q     <= '0;
         time_left_q <= '0;
         winner_q    <= '0;
         timeout_q   <= 1'b0;
         key_q       <= '0;
         score_q     <= '0;
`ifdef FOUL_EN
         foul_q      <= 1'b0;
`endif
      end else begin
         key_q     <= key_i;
         timeout_q <= 1'b0;
`ifdef FOUL_EN
         foul_q    <= 1'b0;
`endif
         if (!endset_i) begin
            // Settings withdrawn: abort silently. Scores and time_left are kept.
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
`ifdef FOUL_EN
                  if (grant_vld_d) begin
                     foul_q <= 1'b1;
                     for (int i = 0; i < N_USER; i++)
                        if (grant_idx_d == 4'(i))
                           score_q[i] <= sub_sat(foul_score_d, scorejian_i);
                  end
`endif
                  if (start_i) begin
                     state_q     <= ARMED;
                     time_left_q <= maxtime_i;
                     presc_q     <= '0;
                  end
               end
               ARMED: begin
                  // A press beats an expiry on the same edge.
                  if (grant_vld_d) begin
                     state_q  <= LOCKED;
                     winner_q <= grant_idx_d;
                  end else if (presc_q == PRE_LAST) begin
                     presc_q <= '0;
                     if (time_left_q == 8'd0) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                     end else begin
                        time_left_q <= time_left_q - 8'd1;
                     end
                  end else begin
                     presc_q <= presc_q + PRE_W'(1);
                  end
               end
               LOCKED: begin
                  // Contradictory judgement (both pulses) is ignored until resolved.
                  if (right_i && !wrong_i) begin
                     state_q <= IDLE;
                     for (int i = 0; i < N_USER; i++)
                        if (winner_q == 4'(i))
                           score_q[i] <= add_sat(win_score_d, scorejia_i);
                  end else if (wrong_i && !right_i) begin
                     state_q <= IDLE;
                     for (int i = 0; i < N_USER; i++)
                        if (winner_q == 4'(i))
                           score_q[i] <= sub_sat(win_score_d, scorejian_i);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign winner_vld_o = (state_q == LOCKED);
   assign winner_o     = winner_q;
   assign time_left_o  = time_left_q;
   assign timeout_o    = timeout_q;
   assign score_o      = score_q;
`ifdef FOUL_EN
   assign foul_o       = foul_q;
`else
   assign foul_o       = 1'b0;
`endif

endmodule

// File: tb/tb_answer_arbiter.sv
// Bench for answer_arbiter (CLK_PER_SEC=4, N_USER=8, SCORE_W=8).
// The reference model tracks elapsed cycles in a round and derives time_left and
// expiry arithmetically; scores are plain integers clamped to 0..255.
module tb_answer_arbiter;
   localparam int N = 8;
   localparam int SW = 8;
   localparam int CPS = 4;

   logic clk = 1'b0, rst = 1'b1, endset = 1'b0, start = 1'b0, right = 1'b0, wrong = 1'b0;
   logic [7:0] maxtime = '0;
   logic [3:0] maxuser = '0, jia = '0, jian = '0;
   logic [N-1:0] key = '0;
   logic busy, winner_vld, timeout, foul;
   logic [3:0] winner;
   logic [7:0] time_left;
   logic [N*SW-1:0] score;

   answer_arbiter #(.N_USER(N), .SCORE_W(SW), .CLK_PER_SEC(CPS)) dut (
      .clk_i(clk), .rst_i(rst), .endset_i(endset), .maxtime_i(maxtime),
      .maxuser_i(maxuser), .scorejia_i(jia), .scorejian_i(jian), .start_i(start),
      .key_i(key), .right_i(right), .wrong_i(wrong), .busy_o(busy),
      .winner_o(winner), .winner_vld_o(winner_vld), .time_left_o(time_left),
      .timeout_o(timeout), .foul_o(foul), .score_o(score));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // model state
   bit m_busy, m_lock, m_to, m_foul;
   int m_el, m_mt, m_tl, m_win;
   int m_sc[N];
   logic [N-1:0] m_prev;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int clampi(input int v);
      return (v < 0) ? 0 : (v > 255) ? 255 : v;
   endfunction

   task automatic model_step();
      int p;
      p = -1;
      m_to = 0;
      m_foul = 0;
      if (rst) begin
         m_busy = 0; m_lock = 0; m_el = 0; m_mt = 0; m_tl = 0; m_win = 0;
         for (int i = 0; i < N; i++) m_sc[i] = 0;
         m_prev = '0;
         return;
      end
      for (int i = N - 1; i >= 0; i--)
         if (key[i] && !m_prev[i] && i < int'(maxuser)) p = i;
      if (!endset) begin
         m_busy = 0; m_lock = 0;
      end else if (!m_busy) begin
`ifdef FOUL_EN
         if (p >= 0) begin
            m_foul = 1;
            m_sc[p] = clampi(m_sc[p] - int'(jian));
         end
`endif
         if (start) begin
            m_busy = 1; m_lock = 0; m_el = 0; m_mt = int'(maxtime); m_tl = m_mt;
         end
      end else if (!m_lock) begin
         if (p >= 0) begin
            m_lock = 1; m_win = p;
         end else begin
            m_el++;
            if (m_el == (m_mt + 1) * CPS) begin
               m_busy = 0; m_to = 1;
            end else m_tl = m_mt - m_el / CPS;
         end
      end else begin
         if (right && !wrong) begin
            m_sc[m_win] = clampi(m_sc[m_win] + int'(jia)); m_busy = 0; m_lock = 0;
         end else if (wrong && !right) begin
            m_sc[m_win] = clampi(m_sc[m_win] - int'(jian)); m_busy = 0; m_lock = 0;
         end
      end
      m_prev = key;
   endtask

   task automatic cmp_all();
      logic [N*SW-1:0] es;
      for (int i = 0; i < N; i++) es[i*SW +: SW] = m_sc[i][SW-1:0];
      chk("model busy", 64'(busy), 64'(m_busy));
      chk("model winner_vld", 64'(winner_vld), 64'(m_lock && m_busy));
      chk("model winner", 64'(winner), 64'(m_win));
      chk("model time_left", 64'(time_left), 64'(m_tl));
      chk("model timeout", 64'(timeout), 64'(m_to));
      chk("model foul", 64'(foul), 64'(m_foul));
      chk("model score", 64'(score), 64'(es));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      cmp_all();
   endtask

   task automatic round(input int u, input bit r, input bit w);
      start = 1; cyc(); start = 0;
      key = N'(1) << u; cyc();
      right = r; wrong = w; cyc();
      right = 0; wrong = 0; key = '0; cyc();
   endtask

   function automatic logic [7:0] sc_of(input int u);
      logic [N*SW-1:0] s;
      s = score;
      return s[u*SW +: SW];
   endfunction

   typedef struct {
      logic st; logic [7:0] k; logic r; logic w;
      logic e_busy; logic e_vld; logic [3:0] e_win; logic [7:0] e_tl; logic e_to;
      int e_idx; logic [7:0] e_sc;
   } vec_t;
   vec_t tbl[12];

   initial begin
      tbl[0]  = '{1, 8'h00, 0, 0, 1, 0, 0, 3, 0, 2, 0};
      tbl[1]  = '{0, 8'h00, 0, 0, 1, 0, 0, 3, 0, 2, 0};
      tbl[2]  = '{0, 8'h00, 0, 0, 1, 0, 0, 3, 0, 2, 0};
      tbl[3]  = '{0, 8'h00, 0, 0, 1, 0, 0, 3, 0, 2, 0};
      tbl[4]  = '{0, 8'h00, 0, 0, 1, 0, 0, 2, 0, 2, 0};
      tbl[5]  = '{0, 8'h04, 0, 0, 1, 1, 2, 2, 0, 2, 0};
      tbl[6]  = '{0, 8'h04, 1, 0, 0, 0, 2, 2, 0, 2, 2};
      tbl[7]  = '{0, 8'h00, 0, 0, 0, 0, 2, 2, 0, 2, 2};
      tbl[8]  = '{1, 8'h00, 0, 0, 1, 0, 2, 3, 0, 2, 2};
      tbl[9]  = '{0, 8'h0A, 0, 0, 1, 1, 1, 3, 0, 3, 0};
      tbl[10] = '{0, 8'h0A, 0, 1, 0, 0, 1, 3, 0, 1, 0};
      tbl[11] = '{0, 8'h00, 1, 0, 0, 0, 1, 3, 0, 2, 2};

      // reset
      rst = 1; cyc(); cyc();
      chk("reset busy", 64'(busy), 0);
      chk("reset winner_vld", 64'(winner_vld), 0);
      chk("reset time_left", 64'(time_left), 0);
      chk("reset score", 64'(score), 0);
      rst = 0; endset = 1; maxuser = 4; maxtime = 3; jia = 2; jian = 1;

      // table: grant, tie, judgement, ignored judgement in IDLE
      foreach (tbl[r]) begin
         start = tbl[r].st; key = tbl[r].k; right = tbl[r].r; wrong = tbl[r].w;
         cyc();
         chk($sformatf("tbl%0d busy", r), 64'(busy), 64'(tbl[r].e_busy));
         chk($sformatf("tbl%0d vld", r), 64'(winner_vld), 64'(tbl[r].e_vld));
         chk($sformatf("tbl%0d winner", r), 64'(winner), 64'(tbl[r].e_win));
         chk($sformatf("tbl%0d time_left", r), 64'(time_left), 64'(tbl[r].e_tl));
         chk($sformatf("tbl%0d timeout", r), 64'(timeout), 64'(tbl[r].e_to));
         chk($sformatf("tbl%0d score", r), 64'(sc_of(tbl[r].e_idx)), 64'(tbl[r].e_sc));
      end
      start = 0; key = '0; right = 0; wrong = 0;

      // countdown: maxtime=2 expires 12 cycles after start
      maxtime = 2; start = 1; cyc(); start = 0;
      chk("cd tl0", 64'(time_left), 2);
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk($sformatf("cd timeout k%0d", k), 64'(timeout), 64'(k == 12));
         if (k < 12)
            chk($sformatf("cd tl k%0d", k), 64'(time_left), (k < 4) ? 2 : (k < 8) ? 1 : 0);
      end
      chk("cd busy after", 64'(busy), 0);
      cyc();
      chk("cd timeout one cycle", 64'(timeout), 0);

      // maxtime=0 expires after CLK_PER_SEC cycles
      maxtime = 0; start = 1; cyc(); start = 0;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk($sformatf("mt0 timeout k%0d", k), 64'(timeout), 64'(k == 4));
      end

      // saturation
      jia = 1; round(0, 1, 0);
      chk("sat score0=1", 64'(sc_of(0)), 1);
      jian = 3; round(0, 0, 1);
      chk("sat floor 0", 64'(sc_of(0)), 0);
      jia = 15; for (int i = 0; i < 16; i++) round(0, 1, 0);
      jia = 14; round(0, 1, 0);
      chk("sat score0=254", 64'(sc_of(0)), 254);
      jia = 5; round(0, 1, 0);
      chk("sat ceil 255", 64'(sc_of(0)), 255);

      // right & wrong together is ignored
      jia = 2; start = 1; cyc(); start = 0; key = 8'h08; cyc();
      right = 1; wrong = 1; cyc();
      chk("both held vld", 64'(winner_vld), 1);
      wrong = 0; cyc(); right = 0; key = '0;
      chk("both then right", 64'(sc_of(3)), 2);

      // endset abort: no timeout, scores kept
      maxtime = 0; start = 1; cyc(); start = 0; cyc();
      endset = 0; cyc();
      chk("abort busy", 64'(busy), 0);
      endset = 1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("abort no timeout", 64'(timeout), 0);
      end

      // maxuser=2: key[5] ignored, then rst during LOCKED
      maxuser = 2; start = 1; cyc(); start = 0;
      key = 8'h20; cyc();
      chk("mu key5 no grant", 64'(winner_vld), 0);
      key = 8'h21; cyc();
      chk("mu key0 grant", 64'(winner_vld), 1);
      rst = 1; cyc(); rst = 0; key = '0;
      chk("rst busy", 64'(busy), 0);
      chk("rst vld", 64'(winner_vld), 0);
      chk("rst tl", 64'(time_left), 0);
      chk("rst score", 64'(score), 0);

      // early press in IDLE
      maxuser = 4; maxtime = 3; jia = 4; round(1, 1, 0);
      jian = 1; key = 8'h02; cyc();
`ifdef FOUL_EN
      chk("foul pulse", 64'(foul), 1);
      chk("foul score", 64'(sc_of(1)), 3);
`else
      chk("foul pulse", 64'(foul), 0);
      chk("foul score", 64'(sc_of(1)), 4);
`endif
      key = '0; cyc();
      chk("foul clears", 64'(foul), 0);

      // random against the model
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         endset = ($urandom_range(0, 49) != 0);
         start = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 2) == 0) key = key ^ (N'(1) << $urandom_range(0, N - 1));
         right = ($urandom_range(0, 3) == 0);
         wrong = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) maxtime = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) maxuser = 4'($urandom_range(0, 15));
         jia = 4'($urandom);
         jian = 4'($urandom);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
